// File: rtl/led_seq_pkg.sv
// Shared types and elaboration helpers for the LED pattern sequencer.
// Step length is computed in 64-bit arithmetic so large clock rates cannot overflow.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  function automatic int step_cycles(input longint clk_hz, input longint step_ms);
    return int'(clk_hz / 64'sd1000 * step_ms);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: free-running 0..STEP_CYC-1 counter that stalls while en is low.
// tick is combinational (same cycle as the terminal count); clr wins over en.
module led_tick_gen #(
  parameter int STEP_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (STEP_CYC > 2) ? $clog2(STEP_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: rotate/bounce/fill/blink, one step per STEP_MS interval.
// led and step_pulse are registered and change together one cycle after the prescaler tick.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int STEP_MS    = 1000,
  parameter int N_LED      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [N_LED-1:0] led,
  output logic             step_pulse
);

  localparam int STEP_CYC = step_cycles(CLK_HZ, STEP_MS);
  localparam int IW       = $clog2(N_LED + 1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(N_LED - 1);
  localparam logic [IW-1:0]    IDX_FULL = IW'(N_LED);
  localparam logic [N_LED-1:0] LED_OFF  = {N_LED{ACTIVE_LOW}};

  if (STEP_CYC < 2) begin : g_bad_step
    $error("led_pattern_seq: STEP_CYC must be at least 2");
  end
  if (N_LED < 2 || N_LED > 32) begin : g_bad_nled
    $error("led_pattern_seq: N_LED must be in 2..32");
  end

  logic tick;

  led_tick_gen #(
    .STEP_CYC(STEP_CYC)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (restart),
    .tick (tick)
  );

  mode_e            mode_in;
  mode_e            mode_q, mode_d;
  logic             started_q, started_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             up_q, up_d;
  logic             step_q, step_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_LED-1:0] pat;
  logic [IW-1:0]    idx_inc, idx_dec;

  assign mode_in = mode_e'(mode);
  assign idx_inc = idx_q + IW'(1);
  assign idx_dec = idx_q - IW'(1);

  always_comb begin
    started_d = started_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    up_d      = up_q;
    step_d    = 1'b0;
    if (tick) begin
      step_d = 1'b1;
      // A fresh start or a mode change restarts the pattern at its first frame.
      if (!started_q || (mode_in != mode_q)) begin
        started_d = 1'b1;
        mode_d    = mode_in;
        case (mode_in)
          MODE_ROTATE: idx_d = dir ? IDX_LAST : '0;
          MODE_BOUNCE: begin
            idx_d = '0;
            up_d  = 1'b1;
          end
          default:     idx_d = IW'(1);
        endcase
      end else begin
        case (mode_q)
          MODE_ROTATE: begin
            if (dir) begin
              idx_d = (idx_q == '0) ? IDX_LAST : idx_dec;
            end else begin
              idx_d = (idx_q == IDX_LAST) ? '0 : idx_inc;
            end
          end
          MODE_BOUNCE: begin
            if (up_q) begin
              idx_d = idx_inc;
              if (idx_inc == IDX_LAST) up_d = 1'b0;
            end else begin
              idx_d = idx_dec;
              if (idx_dec == '0) up_d = 1'b1;
            end
          end
          MODE_FILL:   idx_d = (idx_q == IDX_FULL) ? '0 : idx_inc;
          default:     idx_d = (idx_q == '0) ? IW'(1) : '0;
        endcase
      end
    end
  end

  // Pattern is decoded from next state so led lands on the same edge as step_pulse.
  always_comb begin
    pat = '0;
    if (started_d) begin
      for (int i = 0; i < N_LED; i++) begin
        case (mode_d)
          MODE_ROTATE, MODE_BOUNCE: pat[i] = (IW'(i) == idx_d);
          MODE_FILL:                pat[i] = (IW'(i) < idx_d);
          default:                  pat[i] = (idx_d == IW'(1));
        endcase
      end
    end
  end

  assign led_d = pat ^ LED_OFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      mode_q    <= MODE_ROTATE;
      idx_q     <= '0;
      up_q      <= 1'b1;
      step_q    <= 1'b0;
      led_q     <= LED_OFF;
    end else if (restart) begin
      started_q <= 1'b0;
      mode_q    <= MODE_ROTATE;
      idx_q     <= '0;
      up_q      <= 1'b1;
      step_q    <= 1'b0;
      led_q     <= LED_OFF;
    end else begin
      started_q <= started_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      up_q      <= up_d;
      step_q    <= step_d;
      led_q     <= led_d;
    end
  end

  assign led        = led_q;
  assign step_pulse = step_q;

endmodule
